// File: rtl/ysyx_24100005_lsu.sv
// Multi-cycle load/store unit: latches one request, drives a word-addressed memory
// port, extracts/extends load data and returns a single result with an error flag.
module ysyx_24100005_lsu #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rdata,
    output logic [1:0]        dbg_state
);
    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // a raised valid (req to memory, resp to writeback) holds its payload until then.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MREQ  = 2'd1,
        S_MWAIT = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_wen;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_err;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_misal;
    logic              w_illegal;
    logic              w_bad;
    logic              w_timeout;
    logic [1:0]        w_off;
    logic [31:0]       w_shift;
    logic [31:0]       w_load;
    logic [3:0]        w_mask;
    logic [31:0]       w_wdata;

    // Request legality is judged on the incoming fields, before they are latched.
    always_comb begin
        w_misal = 1'b0;
        case (req_funct3[1:0])
            2'b01:   w_misal = req_addr[0];
            2'b10:   w_misal = (req_addr[1:0] != 2'b00);
            default: w_misal = 1'b0;
        endcase
        if (req_wen) begin
            w_illegal = req_funct3[2] | (req_funct3[1:0] == 2'b11);
        end else begin
            w_illegal = (req_funct3 == 3'b011) | (req_funct3 == 3'b110) |
                        (req_funct3 == 3'b111);
        end
        w_bad = w_misal | w_illegal;
    end

    assign w_timeout = (TIMEOUT_CYC != 0) && (r_cnt == CNT_W'(TIMEOUT_CYC));
    assign w_off     = r_addr[1:0];
    assign w_shift   = mem_rdata >> {w_off, 3'b000};

    always_comb begin
        case (r_funct3)
            3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_load = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b100:  w_load = {24'h0, w_shift[7:0]};
            3'b101:  w_load = {16'h0, w_shift[15:0]};
            default: w_load = w_shift;
        endcase
    end

    always_comb begin
        w_mask  = 4'b0000;
        w_wdata = r_wdata;
        if (r_wen && !r_funct3[2]) begin
            case (r_funct3[1:0])
                2'b00: begin
                    w_mask  = 4'b0001 << w_off;
                    w_wdata = {4{r_wdata[7:0]}};
                end
                2'b01: begin
                    w_mask  = 4'b0011 << w_off;
                    w_wdata = {2{r_wdata[15:0]}};
                end
                2'b10:   w_mask = 4'b1111;
                default: w_mask = 4'b0000;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (req_valid) w_next = w_bad ? S_RESP : S_MREQ;
            S_MREQ:  if (mem_req_ready) w_next = S_MWAIT;
            S_MWAIT: if (mem_rsp_valid || w_timeout) w_next = S_RESP;
            S_RESP:  if (resp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wen    <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= '0;
            r_wdata  <= 32'h0;
            r_rdata  <= 32'h0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (req_valid) begin
                    r_wen    <= req_wen;
                    r_funct3 <= req_funct3;
                    r_addr   <= req_addr;
                    r_wdata  <= req_wdata;
                    r_rdata  <= 32'h0;
                    r_err    <= w_bad;
                end
                S_MREQ: if (mem_req_ready) r_cnt <= '0;
                S_MWAIT: begin
                    // A real response wins over a watchdog expiry in the same cycle.
                    if (mem_rsp_valid) begin
                        r_rdata <= r_wen ? 32'h0 : w_load;
                        r_err   <= 1'b0;
                    end else if (w_timeout) begin
                        r_rdata <= 32'h0;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready     = (r_state == S_IDLE);
    assign resp_valid    = (r_state == S_RESP);
    assign resp_rdata    = r_rdata;
    assign resp_err      = r_err;
    assign mem_req_valid = (r_state == S_MREQ);
    assign mem_wen       = r_wen;
    assign mem_addr      = {r_addr[ADDR_W-1:2], 2'b00};
    assign mem_wdata     = w_wdata;
    assign mem_wmask     = w_mask;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_ysyx_24100005_lsu.sv
// Self-checking bench for ysyx_24100005_lsu: directed cases, timeout, reset abort
// and a randomized run, with expected results queued at request time.
module tb_ysyx_24100005_lsu;
  localparam int ADDR_W = 32;
  localparam int TMO    = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_wen = 1'b0;
  logic [2:0]        req_funct3 = 3'b000;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = 32'h0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              mem_req_valid;
  logic              mem_req_ready = 1'b0;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wmask;
  logic              mem_rsp_valid = 1'b0;
  logic [31:0]       mem_rdata = 32'h0;
  logic [1:0]        dbg_state;

  int n_total = 0;
  int n_bad   = 0;
  logic [32:0] exp_q[$];  // {err, rdata}

  ysyx_24100005_lsu #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL global_timeout: got no end want finish");
    $fatal(1, "bench time limit");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic model_bad(input logic wen, input logic [2:0] f3, input logic [31:0] a);
    if (wen)
      return !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) ||
             (f3 == 3'd1 && a[0]) || (f3 == 3'd2 && a[1:0] != 2'b00);
    return f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 ||
           ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 2'b00);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int o, input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*o +: 8];
    h = (o >= 2) ? w[31:16] : w[15:0];
    case (f3)
      3'd0:    return {{24{b[7]}}, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd4:    return {24'h0, b};
      3'd5:    return {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] model_mask(input logic [2:0] f3, input int o);
    logic [3:0] m;
    for (int i = 0; i < 4; i++)
      m[i] = (f3 == 3'd0) ? (i == o) : (f3 == 3'd1) ? (i == o || i == o + 1) : 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] w);
    case (f3)
      3'd0:    return {4{w[7:0]}};
      3'd1:    return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check_eq({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check_eq({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    check_eq({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    check_eq({tag, "_mem_req_valid"}, 32'(mem_req_valid), 32'd0);
    check_eq({tag, "_mem_wen"}, 32'(mem_wen), 32'd0);
    check_eq({tag, "_mem_wmask"}, 32'(mem_wmask), 32'd0);
    check_eq({tag, "_mem_addr"}, mem_addr, 32'd0);
    check_eq({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check_eq({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  task automatic do_txn(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] word,
                        input int req_dly, input int rsp_dly, input int resp_dly);
    logic        bad;
    logic [32:0] exp;
    int          o;
    int          guard;
    o   = int'(addr[1:0]);
    bad = model_bad(wen, f3, addr);
    if (bad)      exp = {1'b1, 32'h0};
    else if (wen) exp = {1'b0, 32'h0};
    else          exp = {1'b0, model_load(f3, o, word)};
    exp_q.push_back(exp);

    check_eq("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_wen = wen; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    tick;
    req_valid  = 1'b0;
    req_addr   = $urandom;
    req_wdata  = $urandom;
    req_funct3 = 3'($urandom_range(0, 7));
    req_wen    = 1'($urandom_range(0, 1));
    check_eq("req_ready_busy", 32'(req_ready), 32'd0);

    if (!bad) begin
      for (int i = 0; i <= req_dly; i++) begin
        check_eq("mem_req_valid", 32'(mem_req_valid), 32'd1);
        check_eq("mem_addr", mem_addr, {addr[31:2], 2'b00});
        check_eq("mem_wen", 32'(mem_wen), 32'(wen));
        check_eq("mem_wmask", 32'(mem_wmask), wen ? 32'(model_mask(f3, o)) : 32'd0);
        if (wen) check_eq("mem_wdata", mem_wdata, model_wdata(f3, wdata));
        check_eq("resp_valid_mreq", 32'(resp_valid), 32'd0);
        if (i == req_dly) mem_req_ready = 1'b1;
        tick;
        mem_req_ready = 1'b0;
      end
      for (int i = 0; i < rsp_dly; i++) begin
        check_eq("mem_req_valid_wait", 32'(mem_req_valid), 32'd0);
        check_eq("resp_valid_wait", 32'(resp_valid), 32'd0);
        tick;
      end
      mem_rsp_valid = 1'b1;
      mem_rdata     = word;
      tick;
      mem_rsp_valid = 1'b0;
      mem_rdata     = $urandom;
    end else begin
      check_eq("mem_req_valid_err", 32'(mem_req_valid), 32'd0);
    end

    check_eq("resp_valid_latency", 32'(resp_valid), 32'd1);
    guard = 0;
    while (!resp_valid && guard < 10) begin
      tick;
      guard++;
    end
    exp = exp_q.pop_front();
    for (int i = 0; i <= resp_dly; i++) begin
      check_eq("resp_rdata", resp_rdata, exp[31:0]);
      check_eq("resp_err", 32'(resp_err), 32'(exp[32]));
      check_eq("req_ready_resp", 32'(req_ready), 32'd0);
      if (i > 0) check_eq("resp_valid_hold", 32'(resp_valid), 32'd1);
      if (i == resp_dly) resp_ready = 1'b1;
      tick;
      resp_ready = 1'b0;
    end
    check_eq("resp_valid_drop", 32'(resp_valid), 32'd0);
    check_eq("req_ready_back", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [32:0] exp;

    // clock/reset
    #2 rst = 1'b0;
    #1 check_reset_vals("rst0");
    tick;
    tick;
    rst = 1'b1;
    tick;

    // directed cases
    do_txn(1'b0, 3'd0, 32'h8000_0003, 32'h0, 32'h80AB_CDEF, 0, 0, 0);
    do_txn(1'b1, 3'd1, 32'h8000_0002, 32'h1234_BEEF, 32'h0, 0, 0, 0);
    do_txn(1'b0, 3'd2, 32'h8000_0001, 32'h0, 32'h0, 0, 0, 0);
    do_txn(1'b0, 3'd3, 32'h8000_0004, 32'h0, 32'h0, 0, 0, 0);
    do_txn(1'b0, 3'd5, 32'h8000_0002, 32'h0, 32'hF00D_8123, 3, 1, 2);
    do_txn(1'b0, 3'd1, 32'h8000_0002, 32'h0, 32'h9234_5678, 0, 2, 0);
    do_txn(1'b0, 3'd4, 32'h8000_0001, 32'h0, 32'h1122_F344, 1, 0, 1);
    do_txn(1'b0, 3'd2, 32'h8000_0008, 32'h0, 32'hCAFE_F00D, 0, 3, 0);
    do_txn(1'b1, 3'd0, 32'h8000_0001, 32'h0000_00A5, 32'h0, 0, 0, 0);
    do_txn(1'b1, 3'd2, 32'h8000_000C, 32'hDEAD_BEEF, 32'h0, 2, 1, 1);
    do_txn(1'b1, 3'd3, 32'h8000_0000, 32'h1, 32'h0, 0, 0, 0);
    do_txn(1'b1, 3'd1, 32'h8000_0003, 32'h1, 32'h0, 0, 0, 0);

    // watchdog: no response after the memory handshake
    exp_q.push_back({1'b1, 32'h0});
    req_valid = 1'b1; req_wen = 1'b0; req_funct3 = 3'd2; req_addr = 32'h8000_0010;
    mem_req_ready = 1'b1;
    tick;
    req_valid = 1'b0;
    tick;
    mem_req_ready = 1'b0;
    for (int k = 1; k <= TMO; k++) begin
      tick;
      check_eq("tmo_early", 32'(resp_valid), 32'd0);
    end
    tick;
    check_eq("tmo_valid", 32'(resp_valid), 32'd1);
    exp = exp_q.pop_front();
    check_eq("tmo_err", 32'(resp_err), 32'(exp[32]));
    check_eq("tmo_rdata", resp_rdata, exp[31:0]);
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'hDEAD_BEEF;
    tick;
    mem_rsp_valid = 1'b0;
    check_eq("tmo_late_rdata", resp_rdata, exp[31:0]);
    check_eq("tmo_late_err", 32'(resp_err), 32'(exp[32]));
    check_eq("tmo_hold", 32'(resp_valid), 32'd1);
    resp_ready = 1'b1;
    tick;
    resp_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    tick;
    mem_rsp_valid = 1'b0;
    check_eq("late_idle_valid", 32'(resp_valid), 32'd0);
    check_eq("late_idle_state", 32'(dbg_state), 32'd0);
    tick;
    check_eq("late_idle_valid2", 32'(resp_valid), 32'd0);

    // reset while waiting for memory
    req_valid = 1'b1; req_wen = 1'b0; req_funct3 = 3'd2; req_addr = 32'h8000_0020;
    mem_req_ready = 1'b1;
    tick;
    req_valid = 1'b0;
    tick;
    mem_req_ready = 1'b0;
    tick;
    check_eq("abort_in_wait", 32'(dbg_state), 32'd2);
    #2 rst = 1'b0;
    #1 check_reset_vals("rst_mid");
    tick;
    rst = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h1234_5678;
    tick;
    mem_rsp_valid = 1'b0;
    check_reset_vals("rst_after");
    tick;
    check_eq("rst_no_resp", 32'(resp_valid), 32'd0);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      do_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
             $urandom, $urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
